// File: rtl/io_pkg.sv
// Shared definitions for the io_devices arbiter: channel map, FSM encoding, defaults.
package io_pkg;

  localparam logic [3:0] CH_RD_DATA    = 4'd1;
  localparam logic [3:0] CH_RD_COUNTER = 4'd2;
  localparam logic [3:0] CH_RD_CONSOLE = 4'd3;
  localparam logic [3:0] CH_WR_APP     = 4'd1;
  localparam logic [3:0] CH_WR_COUNTER = 4'd2;
  localparam logic [3:0] CH_WR_CONSOLE = 4'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int IO_TIMEOUT_DEF = 16;

  typedef struct packed {
    logic id;
    logic wr;
  } io_req_t;

endpackage

// File: rtl/io_rr_picker.sv
// Two-way round-robin grant; pointer moves to the other requester after each completion.
module io_rr_picker (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [1:0] i_pend,
  input  logic       i_adv,
  input  logic       i_served,
  output logic       o_vld,
  output logic       o_gnt
);

  logic r_ptr;

  always_ff @(posedge clk) begin
    if (reset_i)    r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= ~i_served;
  end

  assign o_vld = |i_pend;
  assign o_gnt = (&i_pend) ? r_ptr : i_pend[1];

endmodule

// File: rtl/io_arbiter.sv
// Shares one io_devices port between the program loader (0) and execution unit (1).
module io_arbiter
  import io_pkg::*;
#(
  parameter int D_WIDTH        = 34,
  parameter int PA_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = IO_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [1:0]          rq_read_req_i,
  input  logic [1:0]          rq_write_req_i,
  input  logic [PA_WIDTH-1:0] rq0_addr_i,
  input  logic [PA_WIDTH-1:0] rq1_addr_i,
  input  logic [D_WIDTH-1:0]  rq0_din_i,
  input  logic [D_WIDTH-1:0]  rq1_din_i,
  output logic [D_WIDTH-1:0]  rq_dout_o,
  output logic [1:0]          rq_ack_o,
  output logic [1:0]          rq_err_o,
  output logic                dev_read_req_o,
  output logic                dev_write_req_o,
  output logic [PA_WIDTH-1:0] dev_read_addr_o,
  output logic [PA_WIDTH-1:0] dev_write_addr_o,
  output logic [D_WIDTH-1:0]  dev_din_o,
  input  logic [D_WIDTH-1:0]  dev_dout_i,
  input  logic                dev_read_ack_i,
  input  logic                dev_write_ack_i
);

  logic [1:0]          r_state;
  io_req_t             r_req;
  logic [PA_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0]  r_din;
  logic [D_WIDTH-1:0]  r_dout;
  logic [7:0]          r_cnt;
  logic                r_err;

  logic w_vld, w_gnt, w_issue, w_done, w_ack;

  io_rr_picker u_pick (
    .clk     (clk),
    .reset_i (reset_i),
    .i_pend  (rq_read_req_i | rq_write_req_i),
    .i_adv   (w_done),
    .i_served(r_req.id),
    .o_vld   (w_vld),
    .o_gnt   (w_gnt)
  );

  assign w_issue = (r_state == ST_ISSUE);
  assign w_done  = (r_state == ST_DONE);
  // Only the ack matching the latched op counts.
  assign w_ack   = r_req.wr ? dev_write_ack_i : dev_read_ack_i;

  assign dev_read_req_o   = w_issue & ~r_req.wr;
  assign dev_write_req_o  = w_issue &  r_req.wr;
  assign dev_read_addr_o  = dev_read_req_o  ? r_addr : '0;
  assign dev_write_addr_o = dev_write_req_o ? r_addr : '0;
  assign dev_din_o        = dev_write_req_o ? r_din  : '0;

  assign rq_ack_o  = w_done ? (r_req.id ? 2'b10 : 2'b01) : 2'b00;
  assign rq_err_o  = rq_ack_o & {2{r_err}};
  assign rq_dout_o = r_dout;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            // A requester with both bits set gets its write served first.
            r_req.id <= w_gnt;
            r_req.wr <= rq_write_req_i[w_gnt];
            r_addr   <= w_gnt ? rq1_addr_i : rq0_addr_i;
            r_din    <= w_gnt ? rq1_din_i  : rq0_din_i;
            r_err    <= 1'b0;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_ack) begin
            r_dout  <= r_req.wr ? '0 : dev_dout_i;
            r_state <= ST_DONE;
          end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            r_cnt   <= r_cnt + 8'd1;
            r_dout  <= '1;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter with a cycle-timestamp reference model and device stub.
module tb_io_arbiter;
  import io_pkg::*;

  localparam int DW = 34;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [1:0]    rq_read_req_i = '0, rq_write_req_i = '0;
  logic [AW-1:0] rq0_addr_i = '0, rq1_addr_i = '0;
  logic [DW-1:0] rq0_din_i = '0, rq1_din_i = '0;
  logic [DW-1:0] rq_dout_o;
  logic [1:0]    rq_ack_o, rq_err_o;
  logic          dev_read_req_o, dev_write_req_o;
  logic [AW-1:0] dev_read_addr_o, dev_write_addr_o;
  logic [DW-1:0] dev_din_o;
  logic [DW-1:0] dev_dout_i = '0;
  logic          dev_read_ack_i = 1'b0, dev_write_ack_i = 1'b0;

  io_arbiter #(.D_WIDTH(DW), .PA_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_i(reset_i),
    .rq_read_req_i(rq_read_req_i), .rq_write_req_i(rq_write_req_i),
    .rq0_addr_i(rq0_addr_i), .rq1_addr_i(rq1_addr_i),
    .rq0_din_i(rq0_din_i), .rq1_din_i(rq1_din_i),
    .rq_dout_o(rq_dout_o), .rq_ack_o(rq_ack_o), .rq_err_o(rq_err_o),
    .dev_read_req_o(dev_read_req_o), .dev_write_req_o(dev_write_req_o),
    .dev_read_addr_o(dev_read_addr_o), .dev_write_addr_o(dev_write_addr_o),
    .dev_din_o(dev_din_o), .dev_dout_i(dev_dout_i),
    .dev_read_ack_i(dev_read_ack_i), .dev_write_ack_i(dev_write_ack_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Device stub: acks one cycle after a request unless killed; stray forces both acks.
  logic          kill = 1'b0, stray = 1'b0;
  logic [DW-1:0] dev_cnt = 34'h100;

  function automatic logic [DW-1:0] dev_val(input logic [AW-1:0] a);
    case (a)
      CH_RD_DATA:    return 34'h12345678;
      CH_RD_COUNTER: return dev_cnt;
      CH_RD_CONSOLE: return 34'h41;
      default:       return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    dev_read_ack_i  <= (dev_read_req_o  & ~kill) | stray;
    dev_write_ack_i <= (dev_write_req_o & ~kill) | stray;
    dev_dout_i      <= dev_read_req_o ? dev_val(dev_read_addr_o) : '0;
  end

  int n_rd = 0, n_wr = 0;
  logic [DW-1:0] last_din = '0;
  always @(negedge clk) begin
    if (dev_read_req_o) n_rd++;
    if (dev_write_req_o) begin n_wr++; last_din = dev_din_o; end
  end

  // Reference model: a transaction granted at cycle g issues at g+1, waits from g+2
  // until the matching ack or TO wait cycles, and completes the cycle after that.
  logic          m_on = 1'b0, m_busy = 1'b0, m_id = 1'b0, m_wr = 1'b0, m_err = 1'b0, m_ptr = 1'b0;
  int            m_g = 0, m_end = -1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0, m_hold = '0;

  always @(negedge clk) begin : model
    logic          e_rd, e_wr, g;
    logic [AW-1:0] e_ra, e_wa;
    logic [DW-1:0] e_din;
    logic [1:0]    e_ack, e_err, p;
    e_rd = 0; e_wr = 0; e_ra = '0; e_wa = '0; e_din = '0; e_ack = '0; e_err = '0;
    if (m_busy && cyc == m_g + 1) begin
      e_rd = !m_wr; e_wr = m_wr;
      if (m_wr) begin e_wa = m_addr; e_din = m_din; end
      else e_ra = m_addr;
    end
    if (m_busy && cyc == m_end) begin
      e_ack[m_id] = 1'b1;
      e_err[m_id] = m_err;
    end
    if (m_on)
      chk("cycle", 128'({dev_read_req_o, dev_write_req_o, dev_read_addr_o, dev_write_addr_o,
                         dev_din_o, rq_ack_o, rq_err_o, rq_dout_o}),
                   128'({e_rd, e_wr, e_ra, e_wa, e_din, e_ack, e_err, m_hold}));
    if (reset_i) begin
      m_on = 1'b1; m_busy = 1'b0; m_hold = '0; m_ptr = 1'b0;
    end else if (!m_busy) begin
      p = rq_read_req_i | rq_write_req_i;
      if (p != 2'b00) begin
        g      = (p == 2'b11) ? m_ptr : p[1];
        m_id   = g;
        m_wr   = rq_write_req_i[g];
        m_addr = g ? rq1_addr_i : rq0_addr_i;
        m_din  = g ? rq1_din_i : rq0_din_i;
        m_busy = 1'b1; m_g = cyc; m_end = -1;
      end
    end else if (cyc == m_end) begin
      m_busy = 1'b0; m_ptr = !m_id;
    end else if (m_end < 0 && cyc >= m_g + 2) begin
      if (m_wr ? dev_write_ack_i : dev_read_ack_i) begin
        m_end = cyc + 1; m_err = 1'b0; m_hold = m_wr ? '0 : dev_dout_i;
      end else if (cyc - (m_g + 1) == TO) begin
        m_end = cyc + 1; m_err = 1'b1; m_hold = '1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rst();
    tick(); reset_i = 1'b1;
    tick(); reset_i = 1'b0;
  endtask

  task automatic wait_ack(input int who, output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rq_ack_o[who]) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_ack%0d: no ack within 60 cycles", who);
    end
  endtask

  task automatic wait_any(output int at, output logic id);
    at = -1; id = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (|rq_ack_o) begin at = cyc; id = rq_ack_o[1]; break; end
    end
    if (at < 0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_any: no ack within 30 cycles");
    end
  endtask

  initial begin
    int n, t, r0, w0, cnt;
    logic id;
    repeat (3) tick();
    chk("reset_outs", 128'({rq_ack_o, rq_err_o, dev_read_req_o, dev_write_req_o, rq_dout_o}), 128'(0));
    reset_i = 1'b0;

    // Requester 1 reads the counter channel.
    rst();
    rq1_addr_i = CH_RD_COUNTER; rq_read_req_i = 2'b10; n = cyc; r0 = n_rd;
    wait_ack(1, t); rq_read_req_i = '0;
    chk("rd_latency", 128'(t), 128'(n + 3));
    chk("rd_counter", 128'(rq_dout_o), 128'(34'h100));
    chk("rd_noerr", 128'(rq_err_o), 128'(0));
    chk("rd_one_pulse", 128'(n_rd - r0), 128'(1));

    // Requester 0 opens app 1 then reads its first word.
    rq0_addr_i = CH_WR_APP; rq0_din_i = 34'h1; rq_write_req_i = 2'b01; w0 = n_wr;
    wait_ack(0, t); rq_write_req_i = '0;
    chk("app_wr_pulse", 128'(n_wr - w0), 128'(1));
    chk("app_wr_din", 128'(last_din), 128'(34'h1));
    chk("app_wr_dout0", 128'(rq_dout_o), 128'(0));
    rq0_addr_i = CH_RD_DATA; rq_read_req_i = 2'b01;
    wait_ack(0, t); rq_read_req_i = '0;
    chk("app_word", 128'(rq_dout_o), 128'(34'h12345678));

    // Both requesters read the console continuously: strict alternation every 4 cycles.
    rst();
    rq0_addr_i = CH_RD_CONSOLE; rq1_addr_i = CH_RD_CONSOLE; rq_read_req_i = 2'b11; n = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_any(t, id);
      chk("rr_id", 128'(id), 128'(k % 2));
      chk("rr_time", 128'(t), 128'(n + 3 + 4 * k));
    end
    rq_read_req_i = '0;

    // Missing device ack: timeout after 16 wait cycles, then a stray ack is ignored.
    rst();
    kill = 1'b1; rq1_addr_i = CH_RD_CONSOLE; rq_read_req_i = 2'b10; n = cyc;
    wait_ack(1, t); rq_read_req_i = '0;
    chk("to_time", 128'(t), 128'(n + 18));
    chk("to_err", 128'(rq_err_o), 128'(2'b10));
    chk("to_dout", 128'(rq_dout_o), 128'(34'h3_FFFF_FFFF));
    kill = 1'b0;
    tick(); stray = 1'b1;
    tick(); stray = 1'b0;
    cnt = 0;
    repeat (6) begin tick(); if (|rq_ack_o || dev_read_req_o || dev_write_req_o) cnt++; end
    chk("stray_quiet", 128'(cnt), 128'(0));

    // Read and write together on one requester: write goes first.
    rst();
    rq0_addr_i = CH_WR_CONSOLE; rq0_din_i = 34'h2A;
    rq_read_req_i = 2'b01; rq_write_req_i = 2'b01; r0 = n_rd; w0 = n_wr;
    wait_ack(0, t); rq_write_req_i = '0;
    chk("rw_wr_first", 128'({n_wr - w0, n_rd - r0}), 128'({32'd1, 32'd0}));
    chk("rw_din", 128'(last_din), 128'(34'h2A));
    wait_ack(0, t); rq_read_req_i = '0;
    chk("rw_rd_next", 128'(n_rd - r0), 128'(1));
    chk("rw_console", 128'(rq_dout_o), 128'(34'h41));

    // Reset while waiting, with requester 1's request held throughout.
    rst();
    kill = 1'b1; rq1_addr_i = CH_RD_COUNTER; rq_read_req_i = 2'b10;
    repeat (4) tick();
    reset_i = 1'b1;
    tick(); reset_i = 1'b0;
    chk("mid_rst_outs", 128'({rq_ack_o, rq_err_o, dev_read_req_o, dev_write_req_o, rq_dout_o}), 128'(0));
    kill = 1'b0; rq0_addr_i = CH_RD_CONSOLE; rq_read_req_i = 2'b11;
    wait_any(t, id); rq_read_req_i = 2'b10;
    chk("rst_ptr0", 128'(id), 128'(0));
    wait_ack(1, t); rq_read_req_i = '0;
    chk("rst_reserve", 128'(rq_dout_o), 128'(34'h100));

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/io_arbiter.md
Name: io_arbiter

Overview:
- Two-requester arbiter that shares the single io_devices port between requester 0 (program loader: channel 1 app select, channel 1 word reads) and requester 1 (execution unit: console and counter channels).
- Turns each requester's level request into exactly one single-cycle device request, waits for the device ack, and returns captured data with a one-cycle ack.
- Round-robin grant, timeout on a missing device ack, no bypass path.

Parameters:
- D_WIDTH, 34, data width of every data port.
- PA_WIDTH, 4, channel address width.
- TIMEOUT_CYCLES, 16, device-ack wait limit in cycles, 2..255.

Ports:
- clk  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- rq_read_req_i  in  2  per-requester read request, level, held until ack; bit n = requester n.
- rq_write_req_i  in  2  per-requester write request, level, held until ack.
- rq0_addr_i  in  PA_WIDTH  requester 0 channel.
- rq1_addr_i  in  PA_WIDTH  requester 1 channel.
- rq0_din_i  in  D_WIDTH  requester 0 write data.
- rq1_din_i  in  D_WIDTH  requester 1 write data.
- rq_dout_o  out  D_WIDTH  read data; valid only with the matching ack bit.
- rq_ack_o  out  2  one-cycle completion pulse per requester.
- rq_err_o  out  2  one-cycle pulse with ack when the transaction timed out.
- dev_read_req_o  out  1  to device read_req_i.
- dev_write_req_o  out  1  to device write_req_i.
- dev_read_addr_o  out  PA_WIDTH  to device read_addr_i.
- dev_write_addr_o  out  PA_WIDTH  to device write_addr_i.
- dev_din_o  out  D_WIDTH  to device din_i.
- dev_dout_i  in  D_WIDTH  from device dout_o.
- dev_read_ack_i  in  1  from device read_ack_o.
- dev_write_ack_i  in  1  from device write_ack_o.

Behaviour:
- Reset: all outputs 0, FSM IDLE, round-robin pointer = requester 0, timeout counter 0. Reset mid-transaction abandons it silently; no ack or err is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: a requester is pending if its read or write bit is set.
  - If both requesters are pending, grant the one the pointer selects; otherwise grant the only pending one.
  - On grant: latch the requester id, the op, the address, and the write data; go to ISSUE.
  - If a requester has both read and write bits set, serve the write first; the read is served on a later grant.
- ISSUE: drive exactly one cycle of dev_read_req_o or dev_write_req_o with the latched address and data; go to WAIT. The unused device address output is held at 0.
- WAIT:
  - Ack present: capture dev_dout_i (reads only; writes return 0 on rq_dout_o) and go to DONE.
  - No ack: increment the counter. When it reaches TIMEOUT_CYCLES, go to DONE with data = all ones and the error flag set.
  - The ack matching the op must be seen: a write_ack during a read is ignored, and vice versa.
- DONE:
  - Pulse rq_ack_o[id] for one cycle; pulse rq_err_o[id] if timed out.
  - Hold rq_dout_o stable this cycle (it is registered).
  - Pointer := other requester, counter := 0, go to IDLE.
- Requester contract: drop the serviced request bit on the edge where it sees ack. The arbiter never samples requests in DONE.
- Latency: request first high in IDLE cycle N → dev req in cycle N+1 → device ack in N+2 → rq_ack_o in N+3. Back-to-back throughput is one transaction per 4 cycles.
- A stray device ack outside WAIT, e.g. late after a timeout, is ignored.
- Request inputs that change while not in IDLE are ignored; the latched values are used.
- No pipelining: at most one device transaction is outstanding.

Decomposition:
- Shared package io_pkg holds:
  - the channel constants (read 1 = data, 2 = counter, 3 = console; write 1 = open app, 2 = counter set, 3 = console);
  - the FSM state encoding (2-bit);
  - the default TIMEOUT_CYCLES.
- One natural sub-module, io_rr_picker: a 2-input round-robin grant from pending bits and pointer, combinational plus pointer update. The FSM and capture registers stay in io_arbiter.

Test Plan:
- Requester 1 reads channel 2 with the device counter at 0x100 → dev_read_req_o high exactly 1 cycle, rq_ack_o = 2'b10 at N+3, rq_dout_o = counter value captured at the device ack, rq_err_o = 0.
- Requester 0 writes channel 1 with data 0x1, then reads channel 1 (app0.bin first word 0x12345678) → one dev write pulse with dev_din_o = 0x1, then a read returning 0x12345678 on the second ack.
- Both requesters read channel 3 continuously from reset → grants alternate 0,1,0,1; acks spaced 4 cycles apart; each requester acked every 8 cycles.
- Device ack forced low, requester 1 reads channel 3 → after 16 WAIT cycles rq_ack_o[1] and rq_err_o[1] pulse together with rq_dout_o = 34'h3_FFFF_FFFF; a later stray ack causes no output.
- Requester 0 asserts read and write on channel 3 together → the write completes first (dev_write_req_o), then the read on the next grant.
- reset_i asserted in WAIT → next cycle all outputs 0, FSM IDLE; a held request is re-served from scratch with the pointer at requester 0.
